// File: rtl/uart_bus_bridge_pkg.sv
// Shared definitions for the UART-to-UIBI bridge: FSM states, CMD byte fields,
// response codes and bus_mode encodings.
package uart_bus_bridge_pkg;

    // Bridge FSM states
    localparam logic [2:0] StCmd  = 3'd0;
    localparam logic [2:0] StAddr = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StBus  = 3'd3;
    localparam logic [2:0] StResp = 3'd4;

    // CMD byte: [7] write enable, [6:2] reserved zero, [1:0] transfer size
    localparam int unsigned CmdWenBit = 7;

    localparam logic [7:0] AckByte = 8'hAC;
    localparam logic [7:0] NakByte = 8'hEE;

    localparam logic [1:0] ModeByte = 2'b00;
    localparam logic [1:0] ModeHalf = 2'b01;
    localparam logic [1:0] ModeWord = 2'b10;

    function automatic logic cmd_is_legal(input logic [7:0] cmd);
        return (cmd[6:2] == 5'b00000) &&
               ((cmd[1:0] == ModeByte) || (cmd[1:0] == ModeHalf) || (cmd[1:0] == ModeWord));
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: two-flop synchroniser, falling-edge start detection with
// half-bit glitch rejection, mid-bit sampling (LSB first) and stop-bit check.
module uart_byte_rx #(
    parameter int unsigned BaudClockNr = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_line,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_rx_active
);

    localparam logic [1:0] RxIdle  = 2'd0;
    localparam logic [1:0] RxStart = 2'd1;
    localparam logic [1:0] RxData  = 2'd2;
    localparam logic [1:0] RxStop  = 2'd3;

    localparam logic [15:0] HalfLast = 16'(BaudClockNr / 2 - 1);
    localparam logic [15:0] BitLast  = 16'(BaudClockNr - 1);

    logic [1:0]  r_sync;
    logic        r_last;
    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_valid;
    logic        w_rx;

    assign w_rx        = r_sync[1];
    assign o_rx_byte   = r_shift;
    assign o_rx_valid  = r_valid;
    assign o_rx_active = (r_state != RxIdle);

    // Synchronise the asynchronous line and keep one more sample for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b11;
            r_last <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_rx_line};
            r_last <= w_rx;
        end
    end

    // Byte framing: validate start at half bit, then sample each bit at its centre
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RxIdle;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                RxIdle: begin
                    if (r_last && !w_rx) begin
                        r_state <= RxStart;
                        r_cnt   <= 16'd0;
                    end
                end
                RxStart: begin
                    if (r_cnt == HalfLast) begin
                        r_cnt   <= 16'd0;
                        r_bit   <= 3'd0;
                        // A high line at mid-start was only a glitch
                        r_state <= w_rx ? RxIdle : RxData;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RxData: begin
                    if (r_cnt == BitLast) begin
                        r_cnt   <= 16'd0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= RxStop;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RxStop: begin
                    if (r_cnt == BitLast) begin
                        r_valid <= w_rx;
                        r_state <= RxIdle;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-to-UIBI bridge: parses CMD/ADDR/DATA frames from the serial line, runs
// one bus transfer per frame and answers with read data, ACK or NAK.
// Optional build macro UART_BRIDGE_TIMEOUT_EN drops partial frames after an
// idle period; without it a partial frame waits until rst.
module uart_bus_bridge
    import uart_bus_bridge_pkg::*;
#(
    parameter int unsigned ClockFreq   = 100000000,
    parameter int unsigned BaudRate    = 115200,
    parameter int unsigned BaudClockNr = ClockFreq / BaudRate
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_line,
    output logic        o_tx_line,
    output logic        o_bus_req,
    output logic        o_bus_wen,
    output logic [1:0]  o_bus_mode,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_dat_o,
    input  logic [31:0] i_bus_dat_i,
    input  logic        i_bus_ready,
    output logic        o_busy
);

    localparam logic [15:0] BitLast = 16'(BaudClockNr - 1);

    logic [2:0]  r_state;
    logic        r_bus_req;
    logic        r_wen;
    logic [1:0]  r_mode;
    logic [31:0] r_addr;
    logic [31:0] r_dat;
    logic [1:0]  r_byte_cnt;
    logic [1:0]  r_resp_left;
    logic [23:0] r_resp_data;
    logic        r_tx_line;
    logic [8:0]  r_tx_frame;
    logic [3:0]  r_tx_bit;
    logic [15:0] r_tx_cnt;

    logic [7:0]  w_rx_byte;
    logic        w_rx_valid;
    logic        w_rx_active;
    logic        w_timeout;
    logic        w_tx_done;
    logic        w_tx_load;
    logic [7:0]  w_tx_byte;

    uart_byte_rx #(
        .BaudClockNr (BaudClockNr)
    ) u_rx (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_line   (i_rx_line),
        .o_rx_byte   (w_rx_byte),
        .o_rx_valid  (w_rx_valid),
        .o_rx_active (w_rx_active)
    );

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam logic [31:0] TimeoutNr = 32'(10 * BaudClockNr * 4);
    logic [31:0] r_to_cnt;

    // Idle timer for partial frames; restarts on every received byte
    always_ff @(posedge i_clk) begin
        if (i_rst || w_rx_valid || !((r_state == StAddr) || (r_state == StData))) begin
            r_to_cnt <= 32'd0;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end
    assign w_timeout = (r_to_cnt == TimeoutNr);
`else
    assign w_timeout = 1'b0;
`endif

    // Decide when a response byte starts and which byte it is
    always_comb begin
        w_tx_done = (r_state == StResp) && (r_tx_cnt == BitLast) && (r_tx_bit == 4'd9);
        w_tx_load = 1'b0;
        w_tx_byte = r_resp_data[7:0];
        if ((r_state == StCmd) && w_rx_valid && !cmd_is_legal(w_rx_byte)) begin
            w_tx_load = 1'b1;
            w_tx_byte = NakByte;
        end else if ((r_state == StBus) && i_bus_ready) begin
            w_tx_load = 1'b1;
            w_tx_byte = r_wen ? AckByte : i_bus_dat_i[7:0];
        end else if (w_tx_done && (r_resp_left != 2'd0)) begin
            w_tx_load = 1'b1;
        end
    end

    // Bridge FSM: frame parsing, bus transfer and response sequencing
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StCmd;
            r_bus_req   <= 1'b0;
            r_wen       <= 1'b0;
            r_mode      <= 2'b00;
            r_addr      <= 32'h0;
            r_dat       <= 32'h0;
            r_byte_cnt  <= 2'd0;
            r_resp_left <= 2'd0;
            r_resp_data <= 24'h0;
        end else begin
            case (r_state)
                StCmd: begin
                    if (w_rx_valid) begin
                        if (cmd_is_legal(w_rx_byte)) begin
                            r_wen      <= w_rx_byte[CmdWenBit];
                            r_mode     <= w_rx_byte[1:0];
                            r_byte_cnt <= 2'd0;
                            r_state    <= StAddr;
                        end else begin
                            r_resp_left <= 2'd0;
                            r_state     <= StResp;
                        end
                    end
                end
                StAddr: begin
                    if (w_timeout) begin
                        r_state <= StCmd;
                    end else if (w_rx_valid) begin
                        r_addr     <= {w_rx_byte, r_addr[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (r_wen) begin
                                r_state <= StData;
                            end else begin
                                r_state   <= StBus;
                                r_bus_req <= 1'b1;
                            end
                        end
                    end
                end
                StData: begin
                    if (w_timeout) begin
                        r_state <= StCmd;
                    end else if (w_rx_valid) begin
                        r_dat      <= {w_rx_byte, r_dat[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state   <= StBus;
                            r_bus_req <= 1'b1;
                        end
                    end
                end
                StBus: begin
                    if (i_bus_ready) begin
                        r_bus_req   <= 1'b0;
                        r_resp_data <= i_bus_dat_i[31:8];
                        r_resp_left <= r_wen ? 2'd0 : 2'd3;
                        r_state     <= StResp;
                    end
                end
                StResp: begin
                    if (w_tx_done) begin
                        if (r_resp_left == 2'd0) begin
                            r_state <= StCmd;
                        end else begin
                            r_resp_left <= r_resp_left - 2'd1;
                            r_resp_data <= {8'h00, r_resp_data[23:8]};
                        end
                    end
                end
                default: r_state <= StCmd;
            endcase
        end
    end

    // TX shifter: r_tx_bit 0 = start, 1..8 = data, 9 = stop; next byte loads with no gap
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_line  <= 1'b1;
            r_tx_frame <= 9'h1FF;
            r_tx_bit   <= 4'd0;
            r_tx_cnt   <= 16'd0;
        end else if (w_tx_load) begin
            r_tx_line  <= 1'b0;
            r_tx_frame <= {1'b1, w_tx_byte};
            r_tx_bit   <= 4'd0;
            r_tx_cnt   <= 16'd0;
        end else if (r_state == StResp) begin
            if (r_tx_cnt == BitLast) begin
                r_tx_cnt <= 16'd0;
                if (r_tx_bit != 4'd9) begin
                    r_tx_line  <= r_tx_frame[0];
                    r_tx_frame <= {1'b1, r_tx_frame[8:1]};
                    r_tx_bit   <= r_tx_bit + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

    assign o_tx_line   = r_tx_line;
    assign o_bus_req   = r_bus_req;
    assign o_bus_wen   = r_wen;
    assign o_bus_mode  = r_mode;
    assign o_bus_addr  = r_addr;
    assign o_bus_dat_o = r_dat;
    assign o_busy      = (r_state != StCmd) || w_rx_active;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge with 16 clocks per bit.
// Frames come from a vector table; bus transfers and TX bytes are checked
// against scoreboard queues filled when each frame is driven.
module tb_uart_bus_bridge;

    localparam int unsigned Bcn       = 16;
    localparam int unsigned TimeoutNr = 10 * Bcn * 4;
    localparam logic [31:0] BadData   = 32'h0BAD0BAD;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        tx;
    logic        req;
    logic        wen;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic        wen;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  delay;   // cycles req stays high; 0 = never ready
    } bus_exp_t;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  delay;
        logic        exp_bus;
        logic [2:0]  exp_n;
        logic [31:0] exp_resp;
    } vec_t;

    bus_exp_t   q_bus[$];
    logic [7:0] q_tx[$];
    vec_t       vecs[8];

    uart_bus_bridge #(
        .BaudClockNr (Bcn)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_line   (rx),
        .o_tx_line   (tx),
        .o_bus_req   (req),
        .o_bus_wen   (wen),
        .o_bus_mode  (mode),
        .o_bus_addr  (addr),
        .o_bus_dat_o (dat_o),
        .i_bus_dat_i (dat_i),
        .i_bus_ready (ready),
        .o_busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (Bcn) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (Bcn) @(negedge clk);
        end
        rx = stop;
        repeat (Bcn) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    task automatic push_resp(input logic [31:0] resp, input int n);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            t = resp >> (8 * i);
            q_tx.push_back(t[7:0]);
        end
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k;
        k = 0;
        while ((busy !== 1'b0) && (k < bound)) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        check({name, "_tx_drained"}, q_tx.size(), 0);
        check({name, "_bus_drained"}, q_bus.size(), 0);
    endtask

    task automatic send_frame(input vec_t v);
        bus_exp_t e;
        if (v.exp_bus) begin
            e = {v.cmd[7], v.cmd[1:0], v.addr, v.wdata, v.rdata, v.delay};
            q_bus.push_back(e);
        end
        push_resp(v.exp_resp, int'(v.exp_n));
        send_byte(v.cmd, 1'b1);
        check("busy_after_cmd", {31'd0, busy}, 32'd1);
        if (v.exp_bus) begin
            send_word(v.addr);
            if (v.cmd[7]) send_word(v.wdata);
        end
        wait_idle("frame_idle", 4000);
    endtask

    // Bus slave model: checks each request against the scoreboard and answers after 'delay'
    initial begin : responder
        bus_exp_t cur;
        int       hi;
        logic     in_txn;
        ready  = 1'b0;
        dat_i  = BadData;
        in_txn = 1'b0;
        hi     = 0;
        cur    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_txn = 1'b0;
                ready  = 1'b0;
                dat_i  = BadData;
            end else if (ready) begin
                ready = 1'b0;
                dat_i = BadData;
                check("bus_req_drop", {31'd0, req}, 32'd0);
                check("bus_req_len", hi, {24'd0, cur.delay});
                in_txn = 1'b0;
            end else if (req) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    hi     = 0;
                    if (q_bus.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL bus_unexpected: got req addr %h expected no request", addr);
                        cur = {wen, mode, addr, dat_o, 32'h0, 8'd1};
                    end else begin
                        cur = q_bus.pop_front();
                    end
                end
                check("bus_wen", {31'd0, wen}, {31'd0, cur.wen});
                check("bus_mode", {30'd0, mode}, {30'd0, cur.mode});
                check("bus_addr", addr, cur.addr);
                if (cur.wen) check("bus_wdata", dat_o, cur.wdata);
                hi++;
                if ((cur.delay != 8'd0) && (hi == int'(cur.delay))) begin
                    ready = 1'b1;
                    dat_i = cur.rdata;
                end
            end else if (in_txn) begin
                in_txn = 1'b0;
                if (cur.delay != 8'd0) check("bus_req_early_drop", {31'd0, req}, 32'd1);
            end
        end
    end

    // TX monitor: decodes 8N1 bytes mid-bit and compares with the expected queue
    initial begin : tx_monitor
        int         prev_start;
        logic [7:0] b;
        logic [7:0] exp_b;
        prev_start = -100000;
        forever begin
            @(negedge clk);
            if (!rst && (tx === 1'b0)) begin
                if (cyc - prev_start < 200) check("tx_back_to_back", cyc - prev_start, Bcn * 10);
                prev_start = cyc;
                repeat (Bcn / 2) @(negedge clk);
                check("tx_start_bit", {31'd0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (Bcn) @(negedge clk);
                    b[i] = tx;
                end
                repeat (Bcn) @(negedge clk);
                check("tx_stop_bit", {31'd0, tx}, 32'd1);
                if (q_tx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %h expected none", b);
                end else begin
                    exp_b = q_tx.pop_front();
                    check("tx_byte", {24'd0, b}, {24'd0, exp_b});
                end
            end
        end
    end

    initial begin : main
        bus_exp_t e;
        int       k;
        vecs[0] = {8'h82, 32'h0000_1000, 32'h1234_5678, 32'h0, 8'd3, 1'b1, 3'd1, 32'h0000_00AC};
        vecs[1] = {8'h02, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 8'd1, 1'b1, 3'd4, 32'hDEAD_BEEF};
        vecs[2] = {8'h03, 32'h0, 32'h0, 32'h0, 8'd0, 1'b0, 3'd1, 32'h0000_00EE};
        vecs[3] = {8'h02, 32'h0000_0008, 32'h0, 32'h0123_4567, 8'd2, 1'b1, 3'd4, 32'h0123_4567};
        vecs[4] = {8'h80, 32'h0000_0003, 32'h0000_00A5, 32'h0, 8'd1, 1'b1, 3'd1, 32'h0000_00AC};
        vecs[5] = {8'h01, 32'hFFFF_FFFE, 32'h0, 32'h8001_7FFE, 8'd5, 1'b1, 3'd4, 32'h8001_7FFE};
        vecs[6] = {8'h42, 32'h0, 32'h0, 32'h0, 8'd0, 1'b0, 3'd1, 32'h0000_00EE};
        vecs[7] = {8'h81, 32'h8000_0000, 32'hCAFE_F00D, 32'h0, 8'd2, 1'b1, 3'd1, 32'h0000_00AC};

        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_line", {31'd0, tx}, 32'd1);
        check("rst_bus_req", {31'd0, req}, 32'd0);
        check("rst_bus_wen", {31'd0, wen}, 32'd0);
        check("rst_bus_mode", {30'd0, mode}, 32'd0);
        check("rst_bus_addr", addr, 32'd0);
        check("rst_bus_dat_o", dat_o, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i]);
        end

        // Short low pulse must be rejected as a glitch
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_idle", {31'd0, busy}, 32'd0);

        // Byte with a zero stop bit is discarded; the next frame parses from its CMD
        send_byte(8'h02, 1'b0);
        repeat (20) @(negedge clk);
        check("framing_err_idle", {31'd0, busy}, 32'd0);
        send_frame(vecs[1]);

        // Reset during a stalled bus cycle
        e = {1'b0, 2'b10, 32'h0000_0010, 32'h0, 32'h0, 8'd0};
        q_bus.push_back(e);
        send_byte(8'h02, 1'b1);
        send_word(32'h0000_0010);
        k = 0;
        while ((req !== 1'b1) && (k < 100)) begin
            @(negedge clk);
            k++;
        end
        check("rst_case_req_seen", {31'd0, req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midbus_rst_req", {31'd0, req}, 32'd0);
        check("midbus_rst_tx", {31'd0, tx}, 32'd1);
        check("midbus_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midbus_rst_bus_consumed", q_bus.size(), 0);
        send_frame(vecs[3]);

        // Partial frame followed by a long idle period
        send_byte(8'h02, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (TimeoutNr + 60) @(negedge clk);
        e = {1'b0, 2'b10, 32'h0000_0020, 32'h0, 32'h5A5A_A5A5, 8'd1};
`ifdef UART_BRIDGE_TIMEOUT_EN
        check("timeout_dropped", {31'd0, busy}, 32'd0);
        check("timeout_no_tx", {31'd0, tx}, 32'd1);
        q_bus.push_back(e);
        push_resp(32'h5A5A_A5A5, 4);
        send_byte(8'h02, 1'b1);
        send_word(32'h0000_0020);
`else
        check("no_timeout_holds", {31'd0, busy}, 32'd1);
        check("no_timeout_no_tx", {31'd0, tx}, 32'd1);
        q_bus.push_back(e);
        push_resp(32'h5A5A_A5A5, 4);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
`endif
        wait_idle("partial_frame_idle", 4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
